bus_req_arbiter: RTL and testbench
==================================

BUS_REQ_ARBITER -- requirements
Module: bus_req_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; STRB_W, default DATA_W/8, write-strobe width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-low.
- req0  in  1  requester 0 (instruction fetch) read request; held until done0.
- addr0  in  ADDR_W  requester 0 address.
- req1  in  1  requester 1 (data) request; held until done1.
- we1  in  1  requester 1: 1 = write, 0 = read.
- addr1  in  ADDR_W  requester 1 address.
- wdata1  in  DATA_W  requester 1 write data.
- wstrb1  in  STRB_W  requester 1 byte enables, active-high.
- done0 / done1  out  1  one-cycle completion pulse per requester.
- rdata  out  DATA_W  read data, valid with done0/done1.
- err  out  1  response error, valid with done0/done1.
- araddr  out  ADDR_W;  arvalid  out  1;  arready  in  1  read-address channel.
- rdata_i  in  DATA_W;  rresp  in  2;  rvalid  in  1;  rready  out  1  read-data channel.
- awaddr  out  ADDR_W;  awvalid  out  1;  awready  in  1  write-address channel.
- wdata  out  DATA_W;  wstrb  out  STRB_W;  wvalid  out  1;  wready  in  1  write-data channel.
- bresp  in  2;  bvalid  in  1;  bready  out  1  write-response channel.

Function
REQ-003 The FSM SHALL have the states IDLE, AR, R, AW, W and B.
REQ-004 In IDLE with at least one request, the block SHALL register the grant, address, we, wdata and wstrb of the winner on the clock edge, then go to AR (read) or AW (write).
REQ-005 Tie-break SHALL be round-robin: the requester not granted last wins; a lone requester always wins.
REQ-006 AR SHALL assert arvalid with the latched address and hold it until arready=1, then go to R.
REQ-007 R SHALL assert rready; when rvalid=1 it SHALL capture rdata_i/rresp, pulse the granted done for one cycle and return to IDLE.
REQ-008 AW SHALL assert awvalid until awready=1, then go to W.
REQ-009 W SHALL assert wvalid with the latched wdata/wstrb until wready=1, then go to B.
REQ-010 B SHALL assert bready; when bvalid=1 it SHALL pulse done1 and return to IDLE.
REQ-011 done and capture SHALL be registered: done appears in the cycle after the rvalid/bvalid handshake, coincident with the return to IDLE.
REQ-012 A requester granted in IDLE SHALL NOT be re-granted before the cycle after its done, because requests deassert on done.
REQ-013 rdata SHALL hold the last captured read data until the next read completes; it is 0 after a write.
REQ-014 err SHALL be 1 when the captured rresp/bresp is nonzero; it is valid only with done.
REQ-015 Valid outputs SHALL be registered.
- Once asserted, valid outputs SHALL NOT drop or change their payload before the handshake.
- Changes on requester inputs after grant SHALL have no effect on the transaction.
REQ-016 Every transaction SHALL be exactly one beat; read and write transactions SHALL never overlap.
REQ-017 Any req0 with no address decode SHALL be forwarded unchanged; addresses SHALL pass through untouched.

Reset
REQ-018 While rst=0, the following SHALL be 0: state (IDLE), all valid/ready outputs, done0, done1, err, rdata and the latched payload.
REQ-019 While rst=0, the round-robin pointer SHALL be reset so that requester 0 wins the first tie.
REQ-020 Reset mid-transaction SHALL abandon the transfer immediately, and no done SHALL be issued for it.

Verification
REQ-021 Read from requester 0:
- Stimulus: req0=1, addr0=0x0000_1000; arready after 2 cycles; rvalid with rdata_i=0xDEAD_BEEF, rresp=0.
- Required: araddr=0x1000; done0 for one cycle; rdata=0xDEAD_BEEF; err=0.
REQ-022 Simultaneous requests after reset:
- Stimulus: req0 and req1 asserted together.
- Required: requester 0 is served first, then requester 1; a repeated tie alternates 1, 0.
REQ-023 Write from requester 1:
- Stimulus: we1=1, addr1=0x8000_0004, wdata1=0x1234_5678, wstrb1=4'b0011; bvalid with bresp=0.
- Required: awaddr=0x8000_0004; wstrb=4'b0011; done1 after bvalid; no AR activity.
REQ-024 Error response:
- Stimulus: bresp=2'b10.
- Required: done1 with err=1.
REQ-025 Stalled slave:
- Stimulus: awready held 0 for 10 cycles while addr1 changes.
- Required: awvalid stays 1 with the original address throughout.
REQ-026 Reset in R state:
- Stimulus: rst pulled low while in R.
- Required: all outputs 0 at once; no done pulse; the next request is served normally.

Source files
------------

// File: rtl/bus_req_arbiter.sv
// Two-requester bus arbiter: instruction fetch (requester 0, read-only) and data
// (requester 1, read/write) share one AXI-lite style master port. One single-beat
// transaction is in flight at a time; ties are broken round-robin.
module bus_req_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [STRB_W-1:0] wstrb1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] AR   = 3'd1;
    localparam logic [2:0] R    = 3'd2;
    localparam logic [2:0] AW   = 3'd3;
    localparam logic [2:0] W    = 3'd4;
    localparam logic [2:0] B    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              grant_q, grant_d;   // 0: requester 0, 1: requester 1
    logic              last_q, last_d;     // requester granted most recently
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // A requester still sees its own done this cycle and has not dropped req yet.
    logic cand0, cand1, pick1;
    assign cand0 = req0 & ~done0_q;
    assign cand1 = req1 & ~done1_q;
    assign pick1 = cand1 & (~cand0 | ~last_q);

    // Next-state and handshake sequencing; done and err are single-cycle pulses.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        rdata_d   = rdata_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cand0 || cand1) begin
                    grant_d = pick1;
                    last_d  = pick1;
                    addr_d  = pick1 ? addr1 : addr0;
                    if (pick1 && we1) begin
                        wdata_d   = wdata1;
                        wstrb_d   = wstrb1;
                        awvalid_d = 1'b1;
                        state_d   = AW;
                    end else begin
                        wdata_d   = '0;
                        wstrb_d   = '0;
                        arvalid_d = 1'b1;
                        state_d   = AR;
                    end
                end
            end
            AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R;
                end
            end
            R: begin
                if (rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = rdata_i;
                    err_d    = |rresp;
                    done0_d  = ~grant_q;
                    done1_d  = grant_q;
                    state_d  = IDLE;
                end
            end
            AW: begin
                if (awready) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    state_d   = W;
                end
            end
            W: begin
                if (wready) begin
                    wvalid_d = 1'b0;
                    bready_d = 1'b1;
                    state_d  = B;
                end
            end
            B: begin
                if (bvalid) begin
                    bready_d = 1'b0;
                    rdata_d  = '0;
                    err_d    = |bresp;
                    done1_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;  // requester 0 wins the first tie
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign awvalid = awvalid_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign err     = err_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Directed self-checking bench for bus_req_arbiter: inputs driven and outputs
// sampled 1 time unit after each rising clock edge.
module tb_bus_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we1;
    logic [31:0] addr0, addr1, wdata1;
    logic [3:0]  wstrb1;
    logic        done0, done1, err;
    logic [31:0] rdata;
    logic [31:0] araddr, awaddr, wdata;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] rdata_i;
    logic [1:0]  rresp, bresp;

    int n_cmp = 0;
    int n_err = 0;

    bus_req_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .addr0   (addr0),
        .req1    (req1),
        .we1     (we1),
        .addr1   (addr1),
        .wdata1  (wdata1),
        .wstrb1  (wstrb1),
        .done0   (done0),
        .done1   (done1),
        .rdata   (rdata),
        .err     (err),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata_i (rdata_i),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Called just after the granting edge; serves one read and stops in the done cycle.
    task automatic do_read(input int g, input logic [31:0] a, input int stall,
                           input logic [31:0] rd, input logic [1:0] rs);
        chk("ar_start", {arvalid, awvalid, araddr}, {1'b1, 1'b0, a});
        for (int i = 0; i < stall; i++) begin
            step;
            chk("ar_hold", {arvalid, araddr}, {1'b1, a});
        end
        arready = 1'b1;
        step;
        arready = 1'b0;
        chk("r_state", {arvalid, rready, done0, done1}, 4'b0100);
        rvalid  = 1'b1;
        rdata_i = rd;
        rresp   = rs;
        step;
        rvalid  = 1'b0;
        rdata_i = '0;
        rresp   = '0;
        chk("r_done", {done0, done1}, (g == 0) ? 2'b10 : 2'b01);
        chk("r_data", rdata, rd);
        chk("r_err", err, (rs != 2'b00));
        chk("r_ready_drop", rready, 1'b0);
    endtask

    // Called just after the granting edge; serves one write and stops in the done cycle.
    task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            input int stall, input logic [1:0] bs);
        chk("aw_start", {awvalid, arvalid, awaddr}, {1'b1, 1'b0, a});
        for (int i = 0; i < stall; i++) begin
            addr1  = $urandom;
            wdata1 = $urandom;
            step;
            chk("aw_hold", {awvalid, arvalid, awaddr}, {1'b1, 1'b0, a});
        end
        awready = 1'b1;
        step;
        awready = 1'b0;
        chk("w_state", {awvalid, wvalid, arvalid}, 3'b010);
        chk("w_payload", {wdata, wstrb}, {wd, ws});
        wready = 1'b1;
        step;
        wready = 1'b0;
        chk("b_state", {wvalid, bready, arvalid}, 3'b010);
        bvalid = 1'b1;
        bresp  = bs;
        step;
        bvalid = 1'b0;
        bresp  = '0;
        chk("b_done", {done0, done1}, 2'b01);
        chk("b_err", err, (bs != 2'b00));
        chk("b_rdata_zero", rdata, 32'h0);
        chk("b_ready_drop", bready, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        {req0, req1, we1, arready, rvalid, awready, wready, bvalid} = '0;
        {addr0, addr1, wdata1, rdata_i} = '0;
        wstrb1 = '0;
        rresp  = '0;
        bresp  = '0;
        step;
        step;
        chk("rst_ctrl", {done0, done1, err, arvalid, rready, awvalid, wvalid, bready}, 8'h00);
        chk("rst_data", {rdata, araddr}, 64'h0);
        chk("rst_wpay", {awaddr, wdata}, 64'h0);
        rst = 1'b1;
        step;
        chk("idle", {arvalid, awvalid}, 2'b00);

        // First tie after reset: 0 then 1.
        req0 = 1'b1; addr0 = 32'h0000_0100;
        req1 = 1'b1; addr1 = 32'h0000_0200; we1 = 1'b0;
        step;
        do_read(0, 32'h0000_0100, 0, 32'hAAAA_0001, 2'b00);
        req0 = 1'b0;
        step;
        do_read(1, 32'h0000_0200, 0, 32'hBBBB_0002, 2'b00);
        req1 = 1'b0;
        step;
        chk("tie1_idle", {arvalid, awvalid, done1}, 3'b000);

        // Lone read from requester 0 with a 2-cycle arready stall.
        req0 = 1'b1; addr0 = 32'h0000_1000;
        step;
        do_read(0, 32'h0000_1000, 2, 32'hDEAD_BEEF, 2'b00);
        // req0 still high during its done cycle must not be re-granted.
        step;
        chk("no_regrant", {arvalid, awvalid, done0}, 3'b000);
        chk("rdata_hold", rdata, 32'hDEAD_BEEF);
        req0 = 1'b0;
        step;

        // Tie with requester 0 granted last: 1 then 0.
        req0 = 1'b1; addr0 = 32'h0000_0300;
        req1 = 1'b1; addr1 = 32'h0000_0400; we1 = 1'b0;
        step;
        do_read(1, 32'h0000_0400, 0, 32'hCCCC_0003, 2'b00);
        req1 = 1'b0;
        step;
        do_read(0, 32'h0000_0300, 0, 32'hDDDD_0004, 2'b01);
        req0 = 1'b0;
        step;

        // Write from requester 1.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h8000_0004;
        wdata1 = 32'h1234_5678; wstrb1 = 4'b0011;
        step;
        do_write(32'h8000_0004, 32'h1234_5678, 4'b0011, 0, 2'b00);
        req1 = 1'b0; we1 = 1'b0;
        step;
        chk("w_done_clr", {done0, done1, err}, 3'b000);

        // Stalled slave for 10 cycles with changing requester inputs; error response.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h8000_0010;
        wdata1 = 32'hCAFE_F00D; wstrb1 = 4'b1100;
        step;
        do_write(32'h8000_0010, 32'hCAFE_F00D, 4'b1100, 10, 2'b10);
        req1 = 1'b0; we1 = 1'b0;
        step;

        // Reset while in R.
        req0 = 1'b1; addr0 = 32'h0000_0500;
        step;
        do_read(0, 32'h0000_0500, 0, 32'h5555_AAAA, 2'b00);
        req0 = 1'b0;
        step;
        req1 = 1'b1; addr1 = 32'h0000_0600;
        step;
        arready = 1'b1;
        step;
        arready = 1'b0;
        chk("pre_rst_r", rready, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_ctrl", {done0, done1, err, arvalid, rready, awvalid, wvalid, bready}, 8'h00);
        chk("rst_async_data", {rdata, araddr}, 64'h0);
        req1 = 1'b0;
        rvalid = 1'b1;
        rdata_i = 32'h0BAD_0BAD;
        step;
        step;
        rvalid = 1'b0;
        rdata_i = '0;
        rst = 1'b1;
        step;
        chk("rst_no_done", {done0, done1, rready, rdata}, 35'h0);

        // Pointer reset: tie goes to requester 0 again.
        req0 = 1'b1; addr0 = 32'h0000_0700;
        req1 = 1'b1; addr1 = 32'h0000_0800; we1 = 1'b0;
        step;
        do_read(0, 32'h0000_0700, 1, 32'h7777_0007, 2'b00);
        req0 = 1'b0;
        step;
        do_read(1, 32'h0000_0800, 0, 32'h8888_0008, 2'b00);
        req1 = 1'b0;
        step;
        chk("final_idle", {arvalid, awvalid, done0, done1}, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
